branch_predict_unit: RTL and testbench

BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

---
 rtl/branch_predict_unit.sv | 66 ++++++
 tb/tb_branch_predict_unit.sv | 138 +++++++++++++
 2 files changed

// File: rtl/branch_predict_unit.sv
// Gshare branch predictor: a PHT of 2-bit saturating counters indexed by PC xor global history,
// with non-speculative training from EX, a same-cycle mispredict flush and resolve/miss statistics.
module branch_predict_unit #(
  parameter int IDX_W = 6,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      pcF,
  input  logic             is_branchF,
  output logic             pred_takeF,
  output logic [IDX_W-1:0] pred_idxF,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_pred,
  input  logic             upd_taken,
  output logic             mispredictE,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int ENTRIES = 1 << IDX_W;

  logic [1:0]       pht [ENTRIES];
  logic [IDX_W-1:0] ghr;
  logic [1:0]       upd_cur;
  logic [1:0]       upd_next;

  // Only the word-aligned low PC bits feed the index.
  logic unused_pc;
  assign unused_pc = ^{pcF[31:IDX_W+2], pcF[1:0]};

  assign pred_idxF   = pcF[IDX_W+1:2] ^ ghr;
  assign pred_takeF  = !rst && is_branchF && pht[pred_idxF][1];
  assign mispredictE = !rst && upd_en && (upd_pred ^ upd_taken);

  assign upd_cur = pht[upd_idx];

  always_comb begin
    // NOTE: assigning a default before any conditional keeps this purely combinational (no latch).
    upd_next = upd_cur;
    if (upd_taken && upd_cur != 2'b11)
      upd_next = upd_cur + 2'd1;
    else if (!upd_taken && upd_cur != 2'b00)
      upd_next = upd_cur - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: every PHT entry must come out of reset as weak-NT, so the table is a resettable
      // register array rather than a RAM macro.
      for (int i = 0; i < ENTRIES; i++) pht[i] <= 2'b01;
      ghr        <= '0;
      branch_cnt <= '0;
      miss_cnt   <= '0;
    end else if (upd_en) begin
      // NOTE: non-blocking writes mean a lookup of the same entry this cycle still reads the
      // pre-update counter and pre-update history.
      pht[upd_idx] <= upd_next;
      ghr          <= {ghr[IDX_W-2:0], upd_taken};
      branch_cnt   <= branch_cnt + CNT_W'(1);
      if (mispredictE) miss_cnt <= miss_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: stimulus pushes hand-computed expectations into a
// queue, and a negedge monitor pops and compares whenever an observation is flagged.
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pcF = '0;
  logic        is_branchF = 1'b0;
  logic        pred_takeF;
  logic [5:0]  pred_idxF;
  logic        upd_en = 1'b0;
  logic [5:0]  upd_idx = '0;
  logic        upd_pred = 1'b0;
  logic        upd_taken = 1'b0;
  logic        mispredictE;
  logic [15:0] branch_cnt;
  logic [15:0] miss_cnt;

  branch_predict_unit #(.IDX_W(6), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .pcF(pcF), .is_branchF(is_branchF),
    .pred_takeF(pred_takeF), .pred_idxF(pred_idxF),
    .upd_en(upd_en), .upd_idx(upd_idx), .upd_pred(upd_pred), .upd_taken(upd_taken),
    .mispredictE(mispredictE), .branch_cnt(branch_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  // mask bits: [0] pred_takeF, [1] pred_idxF, [2] mispredictE, [3] both counters
  typedef struct {
    string       name;
    logic [3:0]  mask;
    logic        pred;
    logic [5:0]  idx;
    logic        mis;
    logic [15:0] bc;
    logic [15:0] mc;
  } exp_t;

  localparam logic [3:0] M_ALL = 4'b1111;
  localparam logic [3:0] M_PM  = 4'b0101;

  exp_t q[$];
  logic obs_valid = 1'b0;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, req);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge.
  task automatic cyc(input logic r, input logic b, input logic [31:0] pc, input logic ue,
                     input logic [5:0] ui, input logic up, input logic ut);
    @(posedge clk);
    #1;
    rst = r; is_branchF = b; pcF = pc;
    upd_en = ue; upd_idx = ui; upd_pred = up; upd_taken = ut;
    obs_valid = 1'b0;
  endtask

  task automatic exp_push(input string n, input logic [3:0] m, input logic p,
                          input logic [5:0] i, input logic mi, input logic [15:0] b,
                          input logic [15:0] c);
    exp_t e;
    e.name = n; e.mask = m; e.pred = p; e.idx = i; e.mis = mi; e.bc = b; e.mc = c;
    q.push_back(e);
    obs_valid = 1'b1;
  endtask

  always @(negedge clk) begin
    if (obs_valid) begin
      if (q.size() == 0) begin
        check("scoreboard_underflow", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (e.mask[0]) check({e.name, "_pred"}, 32'(pred_takeF), 32'(e.pred));
        if (e.mask[1]) check({e.name, "_idx"}, 32'(pred_idxF), 32'(e.idx));
        if (e.mask[2]) check({e.name, "_mis"}, 32'(mispredictE), 32'(e.mis));
        if (e.mask[3]) begin
          check({e.name, "_bcnt"}, 32'(branch_cnt), 32'(e.bc));
          check({e.name, "_mcnt"}, 32'(miss_cnt), 32'(e.mc));
        end
      end
    end
  end

  initial begin
    // Reset with a simultaneous update: outputs forced low.
    cyc(1, 1, 32'h10, 1, 6'h04, 0, 1); exp_push("rst_upd", M_PM, 0, 0, 0, 0, 0);
    // Post-reset lookup.
    cyc(0, 1, 32'h10, 0, 0, 0, 0);     exp_push("reset_lookup", M_ALL, 0, 6'h04, 0, 0, 0);
    // Same-cycle lookup and update of idx 4: pre-update value 01 seen, mispredict flagged.
    cyc(0, 1, 32'h10, 1, 6'h04, 0, 1); exp_push("upd1", M_ALL, 0, 6'h04, 1, 0, 0);
    // GHR=01, pc bits 5 -> idx 4, entry 10.
    cyc(0, 1, 32'h14, 1, 6'h04, 1, 1); exp_push("upd2", M_ALL, 1, 6'h04, 0, 1, 1);
    // GHR=03, pc bits 7 -> idx 4, entry 11.
    cyc(0, 1, 32'h1C, 1, 6'h04, 1, 1); exp_push("upd3", M_ALL, 1, 6'h04, 0, 2, 1);
    // GHR=07, pc bits 3 -> idx 4, entry saturated at 11; upd_pred=0 counts a miss.
    cyc(0, 1, 32'h0C, 1, 6'h04, 0, 1); exp_push("upd4_sat", M_ALL, 1, 6'h04, 1, 3, 1);
    // GHR=0F, pc bits 0B -> idx 4, no update.
    cyc(0, 1, 32'h2C, 0, 0, 0, 0);     exp_push("hold11", M_ALL, 1, 6'h04, 0, 4, 2);
    // Not-taken on idx 4: 11 -> 10.
    cyc(0, 1, 32'h2C, 1, 6'h04, 1, 0); exp_push("dec_from11", M_ALL, 1, 6'h04, 1, 4, 2);
    // GHR=1E, pc bits 1A -> idx 4, entry 10 still predicts taken.
    cyc(0, 1, 32'h68, 0, 0, 0, 0);     exp_push("after_dec", M_ALL, 1, 6'h04, 0, 5, 3);
    cyc(0, 0, 32'h68, 0, 0, 0, 0);     exp_push("not_branch", M_ALL, 0, 6'h04, 0, 5, 3);
    // Mid-operation reset with a pending update; idx 4 would predict taken without rst.
    cyc(1, 1, 32'h68, 1, 6'h04, 0, 1); exp_push("rst_mid", M_PM, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'h10, 0, 0, 0, 0);     exp_push("rst_mid_after", M_ALL, 0, 6'h04, 0, 0, 0);
    // Outcomes 1,0,1,1,0,1 into idx 0x10; with pc=0 the index shows the GHR.
    cyc(0, 0, 32'h0, 1, 6'h10, 0, 1);  exp_push("ghr0", M_ALL, 0, 6'h00, 1, 0, 0);
    cyc(0, 0, 32'h0, 1, 6'h10, 0, 0);  exp_push("ghr1", M_ALL, 0, 6'h01, 0, 1, 1);
    cyc(0, 0, 32'h0, 1, 6'h10, 0, 1);  exp_push("ghr2", M_ALL, 0, 6'h02, 1, 2, 1);
    cyc(0, 0, 32'h0, 1, 6'h10, 0, 1);  exp_push("ghr3", M_ALL, 0, 6'h05, 1, 3, 2);
    cyc(0, 0, 32'h0, 1, 6'h10, 0, 0);  exp_push("ghr4", M_ALL, 0, 6'h0B, 0, 4, 3);
    cyc(0, 0, 32'h0, 1, 6'h10, 0, 1);  exp_push("ghr5", M_ALL, 0, 6'h16, 1, 5, 3);
    // GHR=2D: pc 0x10 -> idx 0x29.
    cyc(0, 1, 32'h10, 0, 0, 0, 0);     exp_push("ghr_2d", M_ALL, 0, 6'h29, 0, 6, 4);
    // Same-cycle lookup and update at 0x29: old value 01 this cycle.
    cyc(0, 1, 32'h10, 1, 6'h29, 0, 1); exp_push("same_cycle", M_ALL, 0, 6'h29, 1, 6, 4);
    // GHR=1B, pc bits 32 -> idx 0x29, entry now 10.
    cyc(0, 1, 32'hC8, 0, 0, 0, 0);     exp_push("next_cycle", M_ALL, 1, 6'h29, 0, 7, 5);
    // upd_en=0 with junk update fields: nothing changes.
    cyc(0, 1, 32'hC8, 0, 6'h29, 1, 0); exp_push("upd_off", M_ALL, 1, 6'h29, 0, 7, 5);
    cyc(0, 1, 32'hC8, 0, 0, 0, 0);     exp_push("upd_off_after", M_ALL, 1, 6'h29, 0, 7, 5);
    cyc(0, 0, 32'h0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    check("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
